// File: rtl/instruction_fetch_queue.sv
// Fetch front end: issues sequential word fetches with credit-limited outstanding requests,
// buffers in-order responses with their PCs, and hands them to decode; redirects flush and restart.
module instruction_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    output logic        o_FetchRequest,
    output logic [31:0] o_FetchAddress,
    input  logic        i_FetchReady,
    input  logic        i_FetchDataValid,
    input  logic [31:0] i_FetchData,
    input  logic        i_Redirect,
    input  logic [31:0] i_RedirectTarget,
    output logic        o_Valid,
    input  logic        i_Ready,
    output logic [31:0] o_InstructionWord,
    output logic [31:0] o_PC,
    output logic [31:0] o_NextPC,
    output logic        o_InstructionAddressMisaligned
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW+1:0] DEPTH_C = (CW+2)'(DEPTH);

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
        logic        mis;
    } entry_t;

    entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        resp_pc_q, resp_pc_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      outst_q, outst_d;
    logic [CW-1:0]      discard_q, discard_d;
    logic               halted_q, halted_d;
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;

    logic [CW+1:0] in_use;
    logic [CW:0]   pending;
    logic          issue, resp_keep, resp_drop, pop;

    // Stale in-flight requests still hold a credit until their responses drain.
    assign in_use = {2'b00, count_q} + {2'b00, outst_q} + {2'b00, discard_q};
    assign o_FetchRequest = !i_Reset && !halted_q && !i_Redirect && (in_use < DEPTH_C);
    assign o_FetchAddress = fetch_pc_q;

    assign issue     = o_FetchRequest && i_FetchReady;
    assign resp_keep = i_FetchDataValid && (discard_q == '0);
    assign resp_drop = i_FetchDataValid && (discard_q != '0);
    assign pop       = (count_q != '0) && i_Ready;
    assign pending   = {1'b0, outst_q} + {1'b0, discard_q};

    always_comb begin
        mem_d      = mem_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        halted_d   = halted_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (i_Redirect) begin
            fetch_pc_d = i_RedirectTarget;
            resp_pc_d  = i_RedirectTarget;
            outst_d    = '0;
            halted_d   = 1'b0;
            head_d     = tail_q;
            count_d    = '0;
            // A response landing in the redirect cycle is itself one of the stale ones.
            if (i_FetchDataValid && (pending != '0))
                discard_d = CW'(pending - 1'b1);
            else
                discard_d = CW'(pending);
            if (i_RedirectTarget[1:0] != 2'b00) begin
                mem_d[tail_q] = '{word: 32'd0, pc: i_RedirectTarget, mis: 1'b1};
                tail_d        = tail_q + PW'(1);
                count_d       = CW'(1);
                halted_d      = 1'b1;
            end
        end else begin
            if (issue)
                fetch_pc_d = fetch_pc_q + 32'd4;
            if (resp_drop)
                discard_d = discard_q - CW'(1);
            if (resp_keep) begin
                mem_d[tail_q] = '{word: i_FetchData, pc: resp_pc_q, mis: 1'b0};
                tail_d        = tail_q + PW'(1);
                resp_pc_d     = resp_pc_q + 32'd4;
            end
            if (pop)
                head_d = head_q + PW'(1);
            outst_d = outst_q + CW'(issue) - CW'(resp_keep);
            count_d = count_q + CW'(resp_keep) - CW'(pop);
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            mem_q      <= '0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            halted_q   <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            mem_q      <= mem_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            halted_q   <= halted_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign o_Valid                        = (count_q != '0);
    assign o_InstructionWord              = mem_q[head_q].word;
    assign o_PC                           = mem_q[head_q].pc;
    assign o_NextPC                       = mem_q[head_q].pc + 32'd4;
    assign o_InstructionAddressMisaligned = mem_q[head_q].mis;

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Parametrised fetch front end that decouples instruction memory from the decode stage of the five-stage RISC-V pipeline. It issues sequential word fetches with up to DEPTH outstanding requests, buffers in-order responses in a DEPTH-entry queue tagged with PC and next-PC, and presents them to the decode stage under a valid/ready handshake. A branch redirect flushes the queue, discards in-flight responses and restarts fetch at the target. This adds buffering, back-pressure and variable memory latency, which single-entry fetch does not support.

## Interface
- DEPTH, default 4: queue entries and maximum outstanding fetches; a power of two, at least 2.
- RESET_PC, default 32'h0000_0000: first fetch address after reset.
- i_Clock  in  1  sole clock; all state updates on its rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- o_FetchRequest  out  1  fetch request valid.
- o_FetchAddress  out  32  word address of the request.
- i_FetchReady  in  1  memory accepts the request this cycle.
- i_FetchDataValid  in  1  in-order response valid; latency of at least 1 cycle, unbounded.
- i_FetchData  in  32  response instruction word.
- i_Redirect  in  1  flush and restart, from the decode-stage branch resolution.
- i_RedirectTarget  in  32  new fetch PC.
- o_Valid  out  1  head entry valid toward the decode stage.
- i_Ready  in  1  decode stage consumes the head entry.
- o_InstructionWord  out  32  head instruction word.
- o_PC  out  32  head entry PC.
- o_NextPC  out  32  head entry PC + 4, modulo 2^32.
- o_InstructionAddressMisaligned  out  1  head entry is a misaligned-target marker.

## Operation
- State:
  - FetchPC, the next address to issue.
  - RespPC, the PC of the next accepted response.
  - Count, the queue occupancy, 0..DEPTH.
  - Outstanding, issued requests not yet returned, 0..DEPTH.
  - Discard, responses still to drop, 0..DEPTH.
  - Halted.
  - Queue pointers, DEPTH-entry circular, wrapping modulo DEPTH.
- Issue:
  - o_FetchRequest = !i_Reset && !Halted && !i_Redirect && (Count + Outstanding < DEPTH).
  - Count and Outstanding are the registered values; a pop does not free a credit until the next cycle.
  - o_FetchAddress = FetchPC.
  - On a request handshake: FetchPC += 4 and Outstanding += 1.
- Response with Discard > 0: the response is dropped; Discard -= 1.
- Response with Discard = 0: {i_FetchData, RespPC} is written at the tail; RespPC += 4, Count += 1, Outstanding -= 1.
- Simultaneous issue and response: Outstanding is unchanged.
- Pop: on o_Valid && i_Ready, the head advances and Count -= 1.
  - Simultaneous push and pop leave Count unchanged.
  - Overflow is impossible by the credit rule.
- Redirect (i_Redirect high) takes priority over every other event that cycle:
  - The queue empties (Count = 0).
  - A pop in the same cycle is ignored.
  - FetchPC and RespPC take i_RedirectTarget.
  - Discard takes Outstanding + Discard, minus 1 if a response arrives that same cycle; that response is dropped.
  - Outstanding takes 0, because discarded requests are tracked only in Discard.
  - Credit rule during discard: requests issue only while Count + Outstanding + Discard < DEPTH.
  - Halted takes 0.
- Misaligned redirect (i_RedirectTarget[1:0] != 0), applied in addition to the above:
  - One marker entry {word 0, PC = target, misaligned = 1} is written to the queue.
  - Halted takes 1, so no fetch is issued until the next redirect.
  - The marker is popped normally; o_NextPC = target + 4.
- Redirect while Halted: clears Halted and applies the normal redirect rules.

## Timing
- Reset values:
  - o_Valid = 0.
  - o_FetchRequest = 0 while i_Reset is high.
  - o_FetchAddress = RESET_PC.
  - o_InstructionWord = 0, o_PC = 0, o_NextPC = 4, o_InstructionAddressMisaligned = 0.
  - All counters 0, Halted = 0.
- First request: asserted in the first cycle after reset deasserts.
- Reset asserted mid-operation: all state is cleared immediately, including Outstanding and Discard. The memory side is reset by the same signal, so no stale response can arrive.
- Latency: a response registered at edge N gives o_Valid = 1 after edge N. There is no fall-through bypass in the response cycle.
- Outputs: o_Valid, o_InstructionWord, o_PC, o_NextPC and o_InstructionAddressMisaligned come from registered queue state only. None depends combinationally on i_Ready or i_FetchDataValid.
- Redirect: o_Valid = 0 in the cycle after the redirect edge. For a misaligned target, o_Valid = 1 with the marker in that cycle instead.
- Throughput: with 1-cycle memory latency and i_Ready held high, one instruction is delivered per cycle.

## Test plan
- Reset, then 1-cycle memory returning address/4 as data, i_Ready high -> first request at 0x0; o_PC sequence 0x0, 0x4, 0x8, … delivered one per cycle; o_NextPC = o_PC + 4.
- i_Ready low with DEPTH=4 -> exactly 4 requests (0x0–0xC) issued, Count = 4, o_FetchRequest low. One pop -> exactly one new request at 0x10, issued the cycle after the pop.
- 3-cycle memory latency with 3 requests outstanding; redirect to 0x100 -> the 3 stale responses are dropped; the first delivered entry has o_PC = 0x100 and the correct data.
- Redirect in the same cycle as a response, a pop and a request -> response dropped; pop ignored; no request that cycle; next request at the target.
- Redirect to 0x102 -> single entry with o_InstructionAddressMisaligned = 1, o_PC = 0x102, o_NextPC = 0x106. No fetches until a redirect to 0x200 resumes fetching at 0x200.
- i_Reset asserted asynchronously mid-burst with a full queue -> o_Valid = 0 and o_FetchRequest = 0 immediately. After release, fetch restarts at RESET_PC.
